test_sign_unit: RTL and testbench
=================================

Name: test_sign_unit

Overview:
- Registered signed/unsigned condition evaluator for the CPU's branch and compare path.
- Takes two 32-bit register operands `rs` and `rt` and a 4-bit condition opcode.
- Produces a single-bit `condition` result, registered, with a valid flag.
- Covers sign tests, equality, signed/unsigned ordering and two's-complement overflow detection. The 0x8000_0000 (most-negative) corner is a first-class case.

Parameters:
- WIDTH, 32, operand width in bits; the sign bit is bit WIDTH-1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- valid_in  input  1  operands and opcode are sampled on this cycle's clock edge when high.
- op  input  4  condition select; encoding under Behaviour.
- rs  input  WIDTH  first operand, two's-complement or unsigned per op.
- rt  input  WIDTH  second operand.
- condition  output  1  registered result of the selected test.
- cond_valid  output  1  high for one cycle when `condition` holds a fresh result.

Behaviour:
- Reset: while `reset` is high, `condition`=0 and `cond_valid`=0, immediately and regardless of clk.
- Latency is 1 cycle. On a rising edge with `valid_in`=1:
  - `condition` <= f(op, rs, rt);
  - `cond_valid` <= 1.
- On a rising edge with `valid_in`=0: `cond_valid` <= 0 and `condition` holds its previous value.
- Fully pipelined: back-to-back `valid_in` every cycle gives a result every cycle. No stall or backpressure.
- Op encoding, with s = signed interpretation and u = unsigned:
  - 0 EQ: rs==rt
  - 1 NE: rs!=rt
  - 2 LTZ: s(rs)<0, i.e. rs[31]
  - 3 LEZ: rs[31] | (rs==0)
  - 4 GTZ: !rs[31] & (rs!=0)
  - 5 GEZ: !rs[31]
  - 6 LT: s(rs)<s(rt)
  - 7 LTU: u(rs)<u(rt)
  - 8 GE: s(rs)>=s(rt)
  - 9 GEU: u(rs)>=u(rt)
  - 10 SAMESIGN: rs[31]==rt[31]
  - 11 DIFFSIGN: rs[31]!=rt[31]
  - 12 ADDOVF: signed overflow of rs+rt, i.e. operand signs equal and sum sign differs
  - 13 SUBOVF: signed overflow of rs-rt, i.e. operand signs differ and difference sign differs from rs
  - 14, 15: reserved; result is 0
- Signed compare must be correct across the full range: 0x8000_0000 is the minimum value, never treated as positive. Use sign-aware compare or a 33-bit subtraction; the 32-bit difference sign alone is not sufficient.
- Overflow detection uses 33-bit arithmetic internally. The wrapped sum/difference is not an output.
- Reset asserted mid-stream discards the in-flight result. The first post-reset result appears one edge after the first `valid_in`.

Decomposition:
- Shared package `sign_pkg`: holds the opcode localparams (OP_EQ … OP_SUBOVF) and the width constant.
- One combinational sub-module `sign_cmp_core` (inputs op, rs, rt; output cond_next) is natural.
- The top level adds only the result and valid registers with async reset.

Test Plan:
- Reset check: assert reset with valid_in=1 and op=EQ → condition=0 and cond_valid=0, and both stay 0 through clock edges while reset is high.
- Most-negative operands: rs=rt=0x8000_0000 over successive cycles → EQ=1, NE=0, LTZ=1, GEZ=0, LT=0, GE=1, SAMESIGN=1, ADDOVF=1, SUBOVF=0; each appears one cycle after issue with cond_valid=1.
- Signed vs unsigned ordering: rs=0x8000_0000, rt=0x0000_0001 → LT=1, LTU=0, GEU=1, DIFFSIGN=1, SUBOVF=1.
- Zero and positive sign tests: rs=0 → LEZ=1, GTZ=0, GEZ=1. rs=0x7FFF_FFFF, rt=1 → ADDOVF=1, GTZ=1, LT=0.
- Reserved and idle behaviour: op=14 with any operands → condition=0. Then valid_in=0 for 2 cycles → cond_valid=0 and condition unchanged.
- Reset mid-stream: issue LT with rs=-1, rt=0, and assert reset asynchronously before the next edge → condition=0 immediately. After release, a new EQ issue with rs=rt=5 → condition=1 one cycle later.

Source files
------------

// File: rtl/sign_pkg.sv
// Shared constants for the branch/compare condition evaluator: operand width
// and the 4-bit condition opcode encoding.
package sign_pkg;

    localparam int DATA_WIDTH = 32;

    localparam logic [3:0] OP_EQ       = 4'd0;
    localparam logic [3:0] OP_NE       = 4'd1;
    localparam logic [3:0] OP_LTZ      = 4'd2;
    localparam logic [3:0] OP_LEZ      = 4'd3;
    localparam logic [3:0] OP_GTZ      = 4'd4;
    localparam logic [3:0] OP_GEZ      = 4'd5;
    localparam logic [3:0] OP_LT       = 4'd6;
    localparam logic [3:0] OP_LTU      = 4'd7;
    localparam logic [3:0] OP_GE       = 4'd8;
    localparam logic [3:0] OP_GEU      = 4'd9;
    localparam logic [3:0] OP_SAMESIGN = 4'd10;
    localparam logic [3:0] OP_DIFFSIGN = 4'd11;
    localparam logic [3:0] OP_ADDOVF   = 4'd12;
    localparam logic [3:0] OP_SUBOVF   = 4'd13;

endpackage

// File: rtl/sign_cmp_core.sv
// Combinational condition evaluator: sign tests, equality, signed/unsigned
// ordering and two's-complement add/sub overflow. Zero latency, no flow control.
module sign_cmp_core
    import sign_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    output logic             cond_next
);

    localparam logic signed [WIDTH:0] SMAX = {2'b00, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH:0] SMIN = {2'b11, {(WIDTH-1){1'b0}}};

    // Sign-extended to WIDTH+1 bits so neither result can wrap; the top bit of
    // the difference is the true signed ordering, even at the most-negative value.
    logic signed [WIDTH:0] w_diff;
    logic signed [WIDTH:0] w_sum;
    logic                  w_rs_neg;
    logic                  w_rt_neg;
    logic                  w_rs_zero;
    logic                  w_eq;
    logic                  w_lt;
    logic                  w_ltu;
    logic                  w_add_ovf;
    logic                  w_sub_ovf;

    assign w_diff    = $signed({rs[WIDTH-1], rs}) - $signed({rt[WIDTH-1], rt});
    assign w_sum     = $signed({rs[WIDTH-1], rs}) + $signed({rt[WIDTH-1], rt});
    assign w_rs_neg  = rs[WIDTH-1];
    assign w_rt_neg  = rt[WIDTH-1];
    assign w_rs_zero = (rs == '0);
    assign w_eq      = (w_diff == '0);
    assign w_lt      = w_diff[WIDTH];
    assign w_ltu     = (rs < rt);
    assign w_add_ovf = (w_sum > SMAX) || (w_sum < SMIN);
    assign w_sub_ovf = w_diff[WIDTH] ^ w_diff[WIDTH-1];

    always_comb begin
        cond_next = 1'b0;
        case (op)
            OP_EQ:       cond_next = w_eq;
            OP_NE:       cond_next = !w_eq;
            OP_LTZ:      cond_next = w_rs_neg;
            OP_LEZ:      cond_next = w_rs_neg | w_rs_zero;
            OP_GTZ:      cond_next = !w_rs_neg & !w_rs_zero;
            OP_GEZ:      cond_next = !w_rs_neg;
            OP_LT:       cond_next = w_lt;
            OP_LTU:      cond_next = w_ltu;
            OP_GE:       cond_next = !w_lt;
            OP_GEU:      cond_next = !w_ltu;
            OP_SAMESIGN: cond_next = (w_rs_neg == w_rt_neg);
            OP_DIFFSIGN: cond_next = (w_rs_neg != w_rt_neg);
            OP_ADDOVF:   cond_next = w_add_ovf;
            OP_SUBOVF:   cond_next = w_sub_ovf;
            default:     cond_next = 1'b0;
        endcase
    end

endmodule

// File: rtl/test_sign_unit.sv
// Registered branch/compare condition unit: one-cycle latency, fully pipelined,
// no backpressure; condition holds across idle cycles, cond_valid pulses per issue.
module test_sign_unit
    import sign_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    output logic             condition,
    output logic             cond_valid
);

    logic w_cond_next;
    logic r_condition;
    logic r_cond_valid;

    sign_cmp_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .op       (op),
        .rs       (rs),
        .rt       (rt),
        .cond_next(w_cond_next)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_condition  <= 1'b0;
            r_cond_valid <= 1'b0;
        end else begin
            r_cond_valid <= valid_in;
            if (valid_in) begin
                r_condition <= w_cond_next;
            end
        end
    end

    assign condition  = r_condition;
    assign cond_valid = r_cond_valid;

endmodule

// File: tb/tb_test_sign_unit.sv
// Directed vector bench for test_sign_unit: table of issues with hand-computed
// results, plus reset, idle-hold and mid-stream reset sequences.
module tb_test_sign_unit;
    import sign_pkg::*;

    logic        clk;
    logic        reset;
    logic        valid_in;
    logic [3:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        condition;
    logic        cond_valid;

    int checks;
    int errors;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic        exp;
        string       name;
    } vec_t;

    localparam int NVEC = 32;
    vec_t vecs[NVEC];

    test_sign_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (valid_in),
        .op        (op),
        .rs        (rs),
        .rt        (rt),
        .condition (condition),
        .cond_valid(cond_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        valid_in = 1'b1;
        op       = o;
        rs       = a;
        rt       = b;
    endtask

    initial begin
        checks = 0;
        errors = 0;

        vecs[0]  = '{OP_EQ,       32'h8000_0000, 32'h8000_0000, 1'b1, "EQ_min_min"};
        vecs[1]  = '{OP_NE,       32'h8000_0000, 32'h8000_0000, 1'b0, "NE_min_min"};
        vecs[2]  = '{OP_LTZ,      32'h8000_0000, 32'h8000_0000, 1'b1, "LTZ_min"};
        vecs[3]  = '{OP_GEZ,      32'h8000_0000, 32'h8000_0000, 1'b0, "GEZ_min"};
        vecs[4]  = '{OP_LT,       32'h8000_0000, 32'h8000_0000, 1'b0, "LT_min_min"};
        vecs[5]  = '{OP_GE,       32'h8000_0000, 32'h8000_0000, 1'b1, "GE_min_min"};
        vecs[6]  = '{OP_SAMESIGN, 32'h8000_0000, 32'h8000_0000, 1'b1, "SAMESIGN_min_min"};
        vecs[7]  = '{OP_ADDOVF,   32'h8000_0000, 32'h8000_0000, 1'b1, "ADDOVF_min_min"};
        vecs[8]  = '{OP_SUBOVF,   32'h8000_0000, 32'h8000_0000, 1'b0, "SUBOVF_min_min"};
        vecs[9]  = '{OP_LT,       32'h8000_0000, 32'h0000_0001, 1'b1, "LT_min_1"};
        vecs[10] = '{OP_LTU,      32'h8000_0000, 32'h0000_0001, 1'b0, "LTU_min_1"};
        vecs[11] = '{OP_GEU,      32'h8000_0000, 32'h0000_0001, 1'b1, "GEU_min_1"};
        vecs[12] = '{OP_DIFFSIGN, 32'h8000_0000, 32'h0000_0001, 1'b1, "DIFFSIGN_min_1"};
        vecs[13] = '{OP_SUBOVF,   32'h8000_0000, 32'h0000_0001, 1'b1, "SUBOVF_min_1"};
        vecs[14] = '{OP_LEZ,      32'h0000_0000, 32'h0000_0000, 1'b1, "LEZ_zero"};
        vecs[15] = '{OP_GTZ,      32'h0000_0000, 32'h0000_0000, 1'b0, "GTZ_zero"};
        vecs[16] = '{OP_GEZ,      32'h0000_0000, 32'h0000_0000, 1'b1, "GEZ_zero"};
        vecs[17] = '{OP_ADDOVF,   32'h7FFF_FFFF, 32'h0000_0001, 1'b1, "ADDOVF_max_1"};
        vecs[18] = '{OP_GTZ,      32'h7FFF_FFFF, 32'h0000_0001, 1'b1, "GTZ_max"};
        vecs[19] = '{OP_LT,       32'h7FFF_FFFF, 32'h0000_0001, 1'b0, "LT_max_1"};
        vecs[20] = '{OP_GE,       32'h7FFF_FFFF, 32'h0000_0001, 1'b1, "GE_max_1"};
        vecs[21] = '{4'd14,       32'h8000_0000, 32'h8000_0000, 1'b0, "RSV14"};
        vecs[22] = '{OP_LTU,      32'h0000_0001, 32'h0000_0002, 1'b1, "LTU_1_2"};
        vecs[23] = '{4'd15,       32'h0000_0001, 32'h0000_0001, 1'b0, "RSV15"};
        vecs[24] = '{OP_LEZ,      32'hFFFF_FFFF, 32'h0000_0000, 1'b1, "LEZ_m1"};
        vecs[25] = '{OP_SUBOVF,   32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, "SUBOVF_max_m1"};
        vecs[26] = '{OP_ADDOVF,   32'h7FFF_FFFF, 32'h0000_0000, 1'b0, "ADDOVF_max_0"};
        vecs[27] = '{OP_SUBOVF,   32'h0000_0000, 32'h8000_0000, 1'b1, "SUBOVF_0_min"};
        vecs[28] = '{OP_NE,       32'h0000_0005, 32'h0000_0006, 1'b1, "NE_5_6"};
        vecs[29] = '{OP_LEZ,      32'h0000_0001, 32'h0000_0000, 1'b0, "LEZ_1"};
        vecs[30] = '{OP_SAMESIGN, 32'h8000_0000, 32'h0000_0001, 1'b0, "SAMESIGN_min_1"};
        vecs[31] = '{OP_ADDOVF,   32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "ADDOVF_min_m1"};

        // Reset held with a live EQ issue on the inputs
        reset    = 1'b1;
        valid_in = 1'b1;
        op       = OP_EQ;
        rs       = 32'd0;
        rt       = 32'd0;
        repeat (2) begin
            @(posedge clk);
            #1;
            check("reset_condition", condition, 1'b0);
            check("reset_cond_valid", cond_valid, 1'b0);
        end
        @(negedge clk);
        reset    = 1'b0;
        valid_in = 1'b0;

        // Back-to-back issues, one result per cycle
        for (int i = 0; i < NVEC; i++) begin
            issue(vecs[i].op, vecs[i].rs, vecs[i].rt);
            @(posedge clk);
            #1;
            check({vecs[i].name, "_cond"}, condition, vecs[i].exp);
            check({vecs[i].name, "_vld"}, cond_valid, 1'b1);
        end

        // Idle cycles hold the last result and drop cond_valid
        issue(OP_EQ, 32'd5, 32'd5);
        @(posedge clk);
        #1;
        check("pre_idle_cond", condition, 1'b1);
        @(negedge clk);
        valid_in = 1'b0;
        op       = 4'd14;
        repeat (2) begin
            @(posedge clk);
            #1;
            check("idle_cond_hold", condition, 1'b1);
            check("idle_vld", cond_valid, 1'b0);
        end

        // Mid-stream asynchronous reset discards the result
        issue(OP_LT, 32'hFFFF_FFFF, 32'd0);
        @(posedge clk);
        #1;
        check("lt_m1_0_cond", condition, 1'b1);
        check("lt_m1_0_vld", cond_valid, 1'b1);
        #1;
        reset = 1'b1;
        #1;
        check("async_rst_cond", condition, 1'b0);
        check("async_rst_vld", cond_valid, 1'b0);
        @(negedge clk);
        reset    = 1'b0;
        valid_in = 1'b0;
        #1;
        check("post_rst_idle_vld", cond_valid, 1'b0);
        issue(OP_EQ, 32'd5, 32'd5);
        @(posedge clk);
        #1;
        check("post_rst_eq_cond", condition, 1'b1);
        check("post_rst_eq_vld", cond_valid, 1'b1);
        @(negedge clk);
        valid_in = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_end_vld", cond_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
